gshare_branch_predictor: RTL and testbench

Parametrised two-level global-history branch predictor with selectable index mode (pure global history or gshare PC-XOR-history). It has separate predict and update ports, so lookup and training of different branches can happen in the same cycle. It also keeps saturating prediction and misprediction counters for performance reporting. It sits beside the fetch stage; the execute stage drives the update port once a branch resolves.

---
 rtl/gshare_branch_predictor_if.sv | 28 ++
 rtl/gshare_branch_predictor.sv | 131 +++++++++++++
 tb/tb_gshare_branch_predictor.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_branch_predictor_if.sv
// Predict/update/perf bundle between fetch, execute and the gshare predictor.
// The predictor takes the slave side; fetch/execute (or a bench) take master.
interface gshare_branch_predictor_if #(
  parameter int IP_WIDTH = 64,
  parameter int IDX_BITS = 8
);
  logic                pred_req;
  logic [IP_WIDTH-1:0] pred_ip;
  logic                pred_valid;
  logic                pred_taken;
  logic [IDX_BITS-1:0] pred_index;
  logic                upd_valid;
  logic [IDX_BITS-1:0] upd_index;
  logic                upd_taken;
  logic                upd_pred;
  logic [31:0]         perf_pred_cnt;
  logic [31:0]         perf_miss_cnt;

  modport master (
    output pred_req, pred_ip, upd_valid, upd_index, upd_taken, upd_pred,
    input  pred_valid, pred_taken, pred_index, perf_pred_cnt, perf_miss_cnt
  );

  modport slave (
    input  pred_req, pred_ip, upd_valid, upd_index, upd_taken, upd_pred,
    output pred_valid, pred_taken, pred_index, perf_pred_cnt, perf_miss_cnt
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Two-level global-history branch predictor (history-only or gshare index),
// with independent predict and update ports, a write-through bypass when both
// touch the same entry in one cycle, and saturating perf counters.
module gshare_branch_predictor #(
  parameter int IP_WIDTH = 64,
  parameter int HIST_LEN = 8,
  parameter int IDX_BITS = 8,
  parameter int CTR_BITS = 2,
  parameter int MODE     = 1,
  parameter int IP_SHIFT = 2
) (
  input logic                     clk,
  input logic                     reset_n,
  gshare_branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};

  // Reject out-of-range configurations at elaboration.
  if (HIST_LEN < 1 || HIST_LEN > IDX_BITS) begin : g_bad_hist
    $error("gshare_branch_predictor: HIST_LEN must be 1..IDX_BITS");
  end
  if (CTR_BITS < 2 || CTR_BITS > 4) begin : g_bad_ctr
    $error("gshare_branch_predictor: CTR_BITS must be 2..4");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("gshare_branch_predictor: MODE must be 0 or 1");
  end
  if (IP_SHIFT < 0 || IP_SHIFT + IDX_BITS > IP_WIDTH) begin : g_bad_ip
    $error("gshare_branch_predictor: IP_SHIFT+IDX_BITS exceeds IP_WIDTH");
  end

  logic [HIST_LEN-1:0] r_ghr;
  logic [CTR_BITS-1:0] r_table [ENTRIES];
  logic                r_pred_valid;
  logic                r_pred_taken;
  logic [IDX_BITS-1:0] r_pred_index;
  logic [31:0]         r_perf_pred_cnt;
  logic [31:0]         r_perf_miss_cnt;

  logic [IDX_BITS-1:0] w_hist;
  logic [IDX_BITS-1:0] w_idx;
  logic [CTR_BITS-1:0] w_upd_old;
  logic [CTR_BITS-1:0] w_upd_new;
  logic [CTR_BITS-1:0] w_rd;
  logic                w_unused_ip;

  // Only a slice of the IP feeds the hash.
  assign w_unused_ip = ^bp.pred_ip;

  // Lookup index always uses the history as it stood before this edge.
  always_comb begin
    w_hist = IDX_BITS'(r_ghr);
    if (MODE == 1) w_idx = bp.pred_ip[IP_SHIFT +: IDX_BITS] ^ w_hist;
    else           w_idx = w_hist;
  end

  // Saturating next value of the entry being trained.
  always_comb begin
    w_upd_old = r_table[bp.upd_index];
    w_upd_new = w_upd_old;
    if (bp.upd_taken) begin
      if (w_upd_old != CTR_MAX) w_upd_new = w_upd_old + 1'b1;
    end else begin
      if (w_upd_old != '0) w_upd_new = w_upd_old - 1'b1;
    end
  end

  // Same-entry predict+update sees the freshly trained counter.
  always_comb begin
    if (bp.upd_valid && (bp.upd_index == w_idx)) w_rd = w_upd_new;
    else                                         w_rd = r_table[w_idx];
  end

  // Pattern table: all entries start weakly not-taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) r_table[i] <= WEAK_NT;
    end else if (bp.upd_valid) begin
      r_table[bp.upd_index] <= w_upd_new;
    end
  end

  // Non-speculative history: shifts only when a branch resolves.
  if (HIST_LEN == 1) begin : g_ghr1
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          r_ghr <= '0;
      else if (bp.upd_valid) r_ghr <= bp.upd_taken;
    end
  end else begin : g_ghrn
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          r_ghr <= '0;
      else if (bp.upd_valid) r_ghr <= {r_ghr[HIST_LEN-2:0], bp.upd_taken};
    end
  end

  // Registered prediction; taken/index hold when no request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_index <= '0;
    end else if (bp.pred_req) begin
      r_pred_valid <= 1'b1;
      r_pred_taken <= w_rd[CTR_BITS-1];
      r_pred_index <= w_idx;
    end else begin
      r_pred_valid <= 1'b0;
    end
  end

  // Perf counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_pred_cnt <= '0;
      r_perf_miss_cnt <= '0;
    end else begin
      if (bp.pred_req && (r_perf_pred_cnt != '1))
        r_perf_pred_cnt <= r_perf_pred_cnt + 32'd1;
      if (bp.upd_valid && (bp.upd_taken != bp.upd_pred) && (r_perf_miss_cnt != '1))
        r_perf_miss_cnt <= r_perf_miss_cnt + 32'd1;
    end
  end

  assign bp.pred_valid    = r_pred_valid;
  assign bp.pred_taken    = r_pred_taken;
  assign bp.pred_index    = r_pred_index;
  assign bp.perf_pred_cnt = r_perf_pred_cnt;
  assign bp.perf_miss_cnt = r_perf_miss_cnt;
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Bench for gshare_branch_predictor: directed vector table and random traffic
// on a gshare instance checked against an array-based model, plus a
// history-only instance for saturation and miss-count sequences.
module tb_gshare_branch_predictor;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  gshare_branch_predictor_if #(.IP_WIDTH(64), .IDX_BITS(8)) if1 ();
  gshare_branch_predictor_if #(.IP_WIDTH(64), .IDX_BITS(8)) if0 ();

  gshare_branch_predictor #(.MODE(1)) u1 (.clk(clk), .reset_n(reset_n), .bp(if1));
  gshare_branch_predictor #(.MODE(0)) u0 (.clk(clk), .reset_n(reset_n), .bp(if0));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Behavioural model of the gshare instance (IP_SHIFT=2, 8-bit index).
  int      m_tab [256];
  int      m_ghr;
  bit      m_pv, m_pt;
  int      m_pi;
  longint  m_pc, m_mc;
  localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

  function automatic void m_reset();
    for (int i = 0; i < 256; i++) m_tab[i] = 1;
    m_ghr = 0; m_pv = 0; m_pt = 0; m_pi = 0; m_pc = 0; m_mc = 0;
  endfunction

  // Training is applied first, so a same-entry lookup reads the new value.
  function automatic void m_edge();
    int idx, u;
    idx = int'((if1.pred_ip >> 2) & 64'hFF) ^ m_ghr;
    if (if1.upd_valid) begin
      u = int'(if1.upd_index);
      if (if1.upd_taken) m_tab[u] = (m_tab[u] < 3) ? m_tab[u] + 1 : 3;
      else               m_tab[u] = (m_tab[u] > 0) ? m_tab[u] - 1 : 0;
      m_ghr = ((m_ghr << 1) | int'(if1.upd_taken)) & 255;
      if (if1.upd_taken != if1.upd_pred && m_mc < SAT) m_mc++;
    end
    if (if1.pred_req) begin
      m_pv = 1; m_pi = idx; m_pt = (m_tab[idx] >= 2);
      if (m_pc < SAT) m_pc++;
    end else begin
      m_pv = 0;
    end
  endfunction

  task automatic tick1();
    m_edge();
    @(posedge clk); #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, if1.pred_valid, m_pv);
    chk({tag, ".taken"}, if1.pred_taken, m_pt);
    chk({tag, ".index"}, if1.pred_index, m_pi);
    chk({tag, ".pcnt"},  if1.perf_pred_cnt, m_pc);
    chk({tag, ".mcnt"},  if1.perf_miss_cnt, m_mc);
  endtask

  task automatic set1(input bit req, input logic [63:0] ip, input bit uv,
                      input logic [7:0] ui, input bit ut, input bit up);
    if1.pred_req = req; if1.pred_ip = ip; if1.upd_valid = uv;
    if1.upd_index = ui; if1.upd_taken = ut; if1.upd_pred = up;
  endtask

  task automatic t0(input bit req, input bit uv, input logic [7:0] ui,
                    input bit ut, input bit up);
    if0.pred_req = req; if0.pred_ip = 64'h0; if0.upd_valid = uv;
    if0.upd_index = ui; if0.upd_taken = ut; if0.upd_pred = up;
    @(posedge clk); #1;
    if0.pred_req = 1'b0; if0.upd_valid = 1'b0;
  endtask

  typedef struct {
    bit          req;
    logic [63:0] ip;
    bit          uv;
    logic [7:0]  ui;
    bit          ut;
    bit          up;
    bit          ev;
    bit          et;
    logic [7:0]  ei;
  } vec_t;

  vec_t vt [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tgts [4];
    logic [7:0] tg;
    tgts[0] = 8'h2A; tgts[1] = 8'h2B; tgts[2] = 8'h10; tgts[3] = 8'h11;

    // Directed vectors, fresh table, GHR=0, upd_pred always 0.
    vt[0] = '{1, 64'h1000, 0, 8'h00, 0, 0, 1, 0, 8'h00};
    vt[1] = '{1, 64'hA8,   1, 8'h2A, 1, 0, 1, 1, 8'h2A}; // bypass 01->10
    vt[2] = '{1, 64'hA8,   0, 8'h00, 0, 0, 1, 0, 8'h2B}; // GHR=1 moves index
    vt[3] = '{0, 64'h0,    1, 8'h2B, 1, 0, 0, 0, 8'h2B}; // hold outputs
    vt[4] = '{1, 64'hA0,   0, 8'h00, 0, 0, 1, 1, 8'h2B};
    vt[5] = '{1, 64'h0,    0, 8'h00, 0, 0, 1, 0, 8'h03};
    vt[6] = '{1, 64'hA4,   1, 8'h2A, 1, 0, 1, 1, 8'h2A}; // 10->11
    vt[7] = '{1, 64'hB4,   1, 8'h2A, 0, 0, 1, 1, 8'h2A}; // 11->10
    vt[8] = '{1, 64'h90,   1, 8'h2A, 0, 0, 1, 0, 8'h2A}; // 10->01

    set1(0, 64'h0, 0, 8'h0, 0, 0);
    if0.pred_req = 0; if0.pred_ip = 0; if0.upd_valid = 0;
    if0.upd_index = 0; if0.upd_taken = 0; if0.upd_pred = 0;
    m_reset();

    // Reset state.
    #11;
    chk("rst.valid", if1.pred_valid, 0);
    chk("rst.taken", if1.pred_taken, 0);
    chk("rst.index", if1.pred_index, 0);
    chk("rst.pcnt",  if1.perf_pred_cnt, 0);
    chk("rst.mcnt",  if1.perf_miss_cnt, 0);
    #1 reset_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      set1(vt[i].req, vt[i].ip, vt[i].uv, vt[i].ui, vt[i].ut, vt[i].up);
      tick1();
      chk($sformatf("vec%0d.valid", i), if1.pred_valid, vt[i].ev);
      chk($sformatf("vec%0d.taken", i), if1.pred_taken, vt[i].et);
      chk($sformatf("vec%0d.index", i), if1.pred_index, vt[i].ei);
      if (i == 0) chk("vec0.pcnt", if1.perf_pred_cnt, 1);
    end
    set1(0, 64'h0, 0, 8'h0, 0, 0);
    chk("vec.pcnt", if1.perf_pred_cnt, 8);
    chk("vec.mcnt", if1.perf_miss_cnt, 3);

    // Random traffic concentrated on a few entries so they saturate often.
    for (int n = 0; n < 400; n++) begin
      tg = tgts[$urandom_range(0, 3)];
      set1($urandom_range(0, 9) < 7,
           ($urandom_range(0, 7) == 0) ? {$urandom, $urandom}
             : ((64'($urandom) << 10) | (64'(tg ^ 8'(m_ghr)) << 2) | 64'($urandom_range(0, 3))),
           $urandom_range(0, 9) < 6, tgts[$urandom_range(0, 3)],
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick1();
      chk_model($sformatf("rnd%0d", n));
    end

    // Async reset between edges while a prediction is valid.
    set1(1, 64'hA8, 0, 8'h0, 0, 0);
    tick1();
    chk("ar.pre_valid", if1.pred_valid, 1);
    set1(0, 64'h0, 0, 8'h0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("ar.valid", if1.pred_valid, 0);
    chk("ar.taken", if1.pred_taken, 0);
    chk("ar.index", if1.pred_index, 0);
    chk("ar.pcnt",  if1.perf_pred_cnt, 0);
    chk("ar.mcnt",  if1.perf_miss_cnt, 0);
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick1();
    chk_model("ar.first");
    // GHR and table cleared: IP 0xA8 maps to 0x2A, weakly not-taken.
    set1(1, 64'hA8, 0, 8'h0, 0, 0);
    tick1();
    chk_model("ar.look");
    chk("ar.look_idx", if1.pred_index, 8'h2A);

    // Prediction counter saturation from a preloaded value.
    set1(0, 64'h0, 0, 8'h0, 0, 0);
    @(negedge clk);
    force u1.r_perf_pred_cnt = 32'hFFFF_FFFE;
    #1 release u1.r_perf_pred_cnt;
    m_pc = 64'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      set1(1, 64'h1000, 0, 8'h0, 0, 0);
      tick1();
      chk_model($sformatf("psat%0d", k));
    end
    chk("psat.final", if1.perf_pred_cnt, 32'hFFFF_FFFF);
    set1(0, 64'h0, 0, 8'h0, 0, 0);

    // History-only instance: saturate entry 7 up, then down, miss counting.
    for (int k = 0; k < 3; k++) t0(0, 1, 8'h07, 1, 1);  // 01->10->11->11, GHR=07
    chk("m0.upd_novalid", if0.pred_valid, 0);
    t0(1, 0, 8'h00, 0, 0);                              // idx = GHR = 07
    chk("m0.up.valid", if0.pred_valid, 1);
    chk("m0.up.taken", if0.pred_taken, 1);
    chk("m0.up.index", if0.pred_index, 8'h07);
    t0(0, 1, 8'h07, 0, 1);                              // 11->10 miss
    t0(0, 1, 8'h07, 0, 0);                              // 10->01
    t0(0, 1, 8'h07, 0, 0);                              // 01->00
    t0(0, 1, 8'h07, 0, 0);                              // 00 stays, GHR=70
    t0(0, 1, 8'h10, 0, 1);                              // miss
    t0(0, 1, 8'h10, 0, 1);                              // miss
    for (int k = 0; k < 3; k++) t0(0, 1, 8'h10, 0, 0);  // GHR=00
    for (int k = 0; k < 3; k++) t0(0, 1, 8'h10, 1, 1);  // GHR=07
    t0(1, 0, 8'h00, 0, 0);
    chk("m0.dn.taken", if0.pred_taken, 0);
    chk("m0.dn.index", if0.pred_index, 8'h07);
    chk("m0.mcnt", if0.perf_miss_cnt, 3);
    chk("m0.pcnt", if0.perf_pred_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
